count_tick_scheduler: RTL and testbench

Controller that sequences the two-digit up/down counter datapath. It owns the run/pause state, the speed level, the count direction and a shared prescaler, and emits one-cycle count-enable ticks with direction. It uses at-max/at-min feedback from the datapath to stop at the 00/99 boundaries. It sits between the debounced/one-pulsed pushbutton layer and the BCD counter/7-segment datapath.

---
 rtl/sched_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/count_tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_count_tick_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types for the count tick scheduler: FSM state encoding and the
// speed level encodings seen on the speed output.
package sched_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    LIMIT = 2'd2
  } sched_state_e;

  localparam logic [1:0] SPD_SLOW   = 2'd0;
  localparam logic [1:0] SPD_NORMAL = 2'd1;
  localparam logic [1:0] SPD_FAST   = 2'd2;

  // Saturating speed step; simultaneous up/down pulses cancel out.
  function automatic logic [1:0] next_speed(input logic [1:0] cur,
                                            input logic up,
                                            input logic down);
    logic [1:0] nxt;
    nxt = cur;
    if (up && !down && cur != SPD_FAST) begin
      nxt = cur + 2'd1;
    end else if (down && !up && cur != SPD_SLOW) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler shared by all speed levels. base_tick fires when
// the low k bits are all ones, k shrinking by one per speed level, so each
// level halves the tick period of the previous one.
module tick_prescaler
  import sched_pkg::*;
#(
  parameter int PRESCALE_W = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       base_tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic [PRESCALE_W-1:0] mask;

  // Next count and the period mask selected by the current speed level.
  always_comb begin
    count_d = clear ? '0 : count_q + PRESCALE_W'(1);
    case (speed)
      SPD_FAST:   mask = {2'b00, {(PRESCALE_W-2){1'b1}}};
      SPD_NORMAL: mask = {1'b0, {(PRESCALE_W-1){1'b1}}};
      default:    mask = {PRESCALE_W{1'b1}};
    endcase
    base_tick = ((count_q & mask) == mask);
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/count_tick_scheduler.sv
// Run/pause/limit controller for the two-digit BCD counter. Issues one-cycle
// count ticks qualified by count_up and stops at the 00/99 boundaries.
// Optional macro AUTO_REVERSE_EN: bounce off the boundaries instead of
// stopping, pulsing limit_hit at each bounce.
module count_tick_scheduler
  import sched_pkg::*;
#(
  parameter int PRESCALE_W = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       dir_lvl,
  input  logic       speed_up_p,
  input  logic       speed_down_p,
  input  logic       at_max,
  input  logic       at_min,
  output logic       tick,
  output logic       count_up,
  output logic [1:0] speed,
  output logic       running,
  output logic       limit_hit
);

  sched_state_e state_q, state_d;
  logic         tick_q, tick_d;
  logic         count_up_q, count_up_d;
  logic [1:0]   speed_q, speed_d;
  logic         running_q, running_d;
  logic         limit_hit_q, limit_hit_d;
  logic         speed_change;
  logic         start_run;
  logic         base_tick;
  logic         at_boundary;
`ifdef AUTO_REVERSE_EN
  logic         rev_q, rev_d;
  logic         dir_prev_q;
  logic         dir_changed;
`endif

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (speed_change | start_run),
    .speed     (speed_q),
    .base_tick (base_tick)
  );

  // Speed level update; any accepted change restarts the prescaler.
  always_comb begin
    speed_d      = next_speed(speed_q, speed_up_p, speed_down_p);
    speed_change = (speed_d != speed_q);
  end

  // Next-state, tick and direction decisions for the run/pause/limit FSM.
  always_comb begin
    state_d     = state_q;
    tick_d      = 1'b0;
    count_up_d  = count_up_q;
    start_run   = 1'b0;
    at_boundary = (count_up_q && at_max) || (!count_up_q && at_min);
`ifdef AUTO_REVERSE_EN
    dir_changed = (dir_lvl != dir_prev_q);
    rev_d       = dir_changed ? 1'b0 : rev_q;
    limit_hit_d = 1'b0;
    case (state_q)
      PAUSE: begin
        if (start_p) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (start_p) begin
          state_d = PAUSE;
        end else if (base_tick) begin
          tick_d = 1'b1;
          if (at_boundary && !dir_changed) begin
            rev_d       = ~rev_q;
            limit_hit_d = 1'b1;
          end
        end
        count_up_d = !dir_lvl ^ rev_d;
      end
      default: state_d = PAUSE;
    endcase
`else
    case (state_q)
      PAUSE: begin
        if (start_p) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        count_up_d = !dir_lvl;
        if (start_p) begin
          state_d = PAUSE;
        end else if (base_tick) begin
          if (at_boundary) begin
            state_d = LIMIT;
          end else begin
            tick_d = 1'b1;
          end
        end
      end
      LIMIT: begin
        count_up_d = !dir_lvl;
        if (start_p) begin
          state_d = PAUSE;
        end else if ((!dir_lvl && !at_max) || (dir_lvl && !at_min)) begin
          state_d = RUN;
        end
      end
      default: state_d = PAUSE;
    endcase
    limit_hit_d = (state_d == LIMIT);
`endif
    running_d = (state_d == RUN);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PAUSE;
      tick_q      <= 1'b0;
      count_up_q  <= 1'b1;
      speed_q     <= SPD_SLOW;
      running_q   <= 1'b0;
      limit_hit_q <= 1'b0;
`ifdef AUTO_REVERSE_EN
      rev_q       <= 1'b0;
      dir_prev_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      count_up_q  <= count_up_d;
      speed_q     <= speed_d;
      running_q   <= running_d;
      limit_hit_q <= limit_hit_d;
`ifdef AUTO_REVERSE_EN
      rev_q       <= rev_d;
      dir_prev_q  <= dir_lvl;
`endif
    end
  end

  assign tick      = tick_q;
  assign count_up  = count_up_q;
  assign speed     = speed_q;
  assign running   = running_q;
  assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_count_tick_scheduler.sv
// Directed bench for count_tick_scheduler with PRESCALE_W=4
// (SLOW 16, NORMAL 8, FAST 4 cycles). Expected latencies are hand-derived.
module tb_count_tick_scheduler;

  localparam int PW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_p;
  logic       dir_lvl;
  logic       speed_up_p;
  logic       speed_down_p;
  logic       at_max;
  logic       at_min;
  logic       tick;
  logic       count_up;
  logic [1:0] speed;
  logic       running;
  logic       limit_hit;

  int testsRun    = 0;
  int testsFailed = 0;

  count_tick_scheduler #(
    .PRESCALE_W(PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_p      (start_p),
    .dir_lvl      (dir_lvl),
    .speed_up_p   (speed_up_p),
    .speed_down_p (speed_down_p),
    .at_max       (at_max),
    .at_min       (at_min),
    .tick         (tick),
    .count_up     (count_up),
    .speed        (speed),
    .running      (running),
    .limit_hit    (limit_hit)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic u, input logic d);
    start_p      = s;
    speed_up_p   = u;
    speed_down_p = d;
    @(posedge clk);
    #1;
    start_p      = 1'b0;
    speed_up_p   = 1'b0;
    speed_down_p = 1'b0;
  endtask

  // Returns edges until tick is seen, or 999 if the budget runs out.
  task automatic waitTick(output int n);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int limitAt;
  int sawTick;

  // Directed scenario sequence.
  initial begin
    rst_n        = 1'b0;
    start_p      = 1'b0;
    dir_lvl      = 1'b0;
    speed_up_p   = 1'b0;
    speed_down_p = 1'b0;
    at_max       = 1'b0;
    at_min       = 1'b0;
    stepCycles(3);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_count_up", count_up, 1);
    checkOutput("rst_speed", speed, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_limit_hit", limit_hit, 0);
    rst_n = 1'b1;
    stepCycles(2);
    checkOutput("idle_running", running, 0);

    // Start at SLOW: ticks every 16 cycles counting up.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_running", running, 1);
    waitTick(n);
    checkOutput("slow_first_tick", n, 16);
    checkOutput("slow_count_up", count_up, 1);
    stepCycles(1);
    checkOutput("tick_one_cycle", tick, 0);
    waitTick(n);
    checkOutput("slow_second_tick", n, 15);

    // Speed up three times: 1, 2, then saturate at 2.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("speed_up_1", speed, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("speed_up_2", speed, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("speed_sat", speed, 2);
    waitTick(n);
    checkOutput("fast_first_tick", n, 3);
    waitTick(n);
    checkOutput("fast_second_tick", n, 4);

    // Drop to NORMAL, then both pulses together: no change, no clear.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("speed_down", speed, 1);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("speed_both", speed, 1);
    waitTick(n);
    checkOutput("both_no_clear", n, 5);

`ifndef AUTO_REVERSE_EN
    // Reach 99 counting up: stop in LIMIT without a tick.
    at_max  = 1'b1;
    limitAt = 0;
    sawTick = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (tick) sawTick = 1;
      if (limit_hit && limitAt == 0) limitAt = i;
    end
    checkOutput("limit_latency", limitAt, 8);
    checkOutput("limit_no_tick", sawTick, 0);
    checkOutput("limit_running", running, 0);
    dir_lvl = 1'b1;
    stepCycles(2);
    checkOutput("leave_limit_running", running, 1);
    checkOutput("leave_limit_hit", limit_hit, 0);
    checkOutput("leave_limit_dir", count_up, 0);
    at_max = 1'b0;
    waitTick(n);
    checkOutput("resume_tick", n, 2);
    checkOutput("resume_dir", count_up, 0);
`endif

    // start_p coincident with base_tick: pause, no tick.
    dir_lvl = 1'b1;
    waitTick(n);
    checkOutput("align_tick", n, 8);
    stepCycles(7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("coincide_tick", tick, 0);
    checkOutput("coincide_running", running, 0);
    dir_lvl = 1'b0;
    stepCycles(3);
    checkOutput("pause_dir_held", count_up, 0);
    checkOutput("pause_no_tick", tick, 0);

`ifdef AUTO_REVERSE_EN
    // Bounce off 00 counting down.
    dir_lvl = 1'b1;
    at_min  = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ar_running", running, 1);
    waitTick(n);
    checkOutput("ar_tick", n, 8);
    checkOutput("ar_dir", count_up, 1);
    checkOutput("ar_limit_pulse", limit_hit, 1);
    checkOutput("ar_still_running", running, 1);
    stepCycles(1);
    checkOutput("ar_limit_clear", limit_hit, 0);
    waitTick(n);
    checkOutput("ar_next_tick", n, 7);
    checkOutput("ar_next_dir", count_up, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
